// File: rtl/hazard_interlock_ctrl_pkg.sv
// SimpleRISC opcode map and operand-class helpers shared by the issue controller.
package simplerisc_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_LSL  = 5'b01010;
  localparam logic [4:0] OP_LSR  = 5'b01011;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [3:0]  RA_REG    = 4'd15;
  localparam int unsigned NUM_CNT   = 17;
  // Scoreboard slot 16 tracks the flags register.
  localparam logic [4:0]  FLAGS_IDX = 5'd16;

  typedef enum logic {RUN, BR_WAIT} ic_state_e;

  function automatic logic writes_rd(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR,
                      OP_NOT, OP_MOV, OP_LSL, OP_LSR, OP_ASR, OP_LD};
  endfunction

  function automatic logic reads_rs1(input logic [4:0] op);
    return (writes_rd(op) && !(op inside {OP_NOT, OP_MOV})) || op == OP_CMP || op == OP_ST;
  endfunction

  function automatic logic reads_rs2(input logic [4:0] op, input logic imm);
    return !imm && (reads_rs1(op) || op == OP_NOT || op == OP_MOV);
  endfunction

  function automatic logic reads_rd(input logic [4:0] op);
    return op == OP_ST;
  endfunction

  function automatic logic reads_flags(input logic [4:0] op);
    return op == OP_BEQ || op == OP_BGT;
  endfunction

  function automatic logic is_ctrl(input logic [4:0] op);
    return op inside {OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_RET};
  endfunction

  function automatic logic is_ld(input logic [4:0] op);
    return op == OP_LD;
  endfunction

endpackage

// File: rtl/hazard_interlock_ctrl_reg_scoreboard.sv
// Per-register countdown scoreboard: one write port, three combinational read ports.
module reg_scoreboard
  import simplerisc_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en_i,
  input  logic [4:0]       set_addr_i,
  input  logic [CNT_W-1:0] set_val_i,
  input  logic [4:0]       rd_addr_a_i,
  input  logic [4:0]       rd_addr_b_i,
  input  logic [4:0]       rd_addr_c_i,
  output logic [CNT_W-1:0] rd_cnt_a_o,
  output logic [CNT_W-1:0] rd_cnt_b_o,
  output logic [CNT_W-1:0] rd_cnt_c_o
);

  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic [CNT_W-1:0] cnt_d [NUM_CNT];

  // A same-cycle load takes precedence over the free-running decrement.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
      if (set_en_i && set_addr_i == 5'(i)) cnt_d[i] = set_val_i;
    end
  end

  always_comb begin
    rd_cnt_a_o = '0;
    rd_cnt_b_o = '0;
    rd_cnt_c_o = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (rd_addr_a_i == 5'(i)) rd_cnt_a_o = cnt_q[i];
      if (rd_addr_b_i == 5'(i)) rd_cnt_b_o = cnt_q[i];
      if (rd_addr_c_i == 5'(i)) rd_cnt_c_o = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/hazard_interlock_ctrl.sv
// Decode-to-execute issue controller: RAW interlock via scoreboard, wrong-path flush after branches.
module hazard_interlock_ctrl
  import simplerisc_pkg::*;
#(
  parameter int unsigned WB_DIST    = 3,
  parameter int unsigned LD_DIST    = 4,
  parameter int unsigned FLAG_DIST  = 2,
  parameter int unsigned BR_BUBBLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_opcode,
  input  logic       id_imm,
  input  logic [3:0] id_rs1,
  input  logic [3:0] id_rs2,
  input  logic [3:0] id_rd,
  output logic       issue,
  output logic       stall_if_id,
  output logic       bubble_id_ex,
  output logic       flush_if_id
);

  localparam int unsigned MAX_WL   = (WB_DIST > LD_DIST) ? WB_DIST : LD_DIST;
  localparam int unsigned MAX_DIST = (MAX_WL > FLAG_DIST) ? MAX_WL : FLAG_DIST;
  localparam int unsigned CNT_W    = $clog2(MAX_DIST + 1);
  localparam int unsigned BRC_W    = (BR_BUBBLES < 2) ? 1 : $clog2(BR_BUBBLES + 1);

  ic_state_e        state_q;
  logic [BRC_W-1:0] brc_q;

  logic [4:0]       addr_a, addr_b, addr_c, set_addr;
  logic             use_a, use_b, use_c, hazard, set_en;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c, set_val;

  // ret checks r15 and beq/bgt check flags through the RS1 read port.
  always_comb begin
    addr_a = {1'b0, id_rs1};
    use_a  = reads_rs1(id_opcode);
    if (id_opcode == OP_RET) begin
      addr_a = {1'b0, RA_REG};
      use_a  = 1'b1;
    end else if (reads_flags(id_opcode)) begin
      addr_a = FLAGS_IDX;
      use_a  = 1'b1;
    end
    addr_b = {1'b0, id_rs2};
    use_b  = reads_rs2(id_opcode, id_imm);
    addr_c = {1'b0, id_rd};
    use_c  = reads_rd(id_opcode);
  end

  assign hazard = id_valid && ((use_a && cnt_a != '0) ||
                               (use_b && cnt_b != '0) ||
                               (use_c && cnt_c != '0));

  always_comb begin
    issue        = 1'b0;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    if (rst) begin
      if (state_q == BR_WAIT) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (!id_valid) begin
        bubble_id_ex = 1'b1;
      end else if (hazard) begin
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else begin
        issue = 1'b1;
      end
    end
  end

  always_comb begin
    set_en   = issue && (writes_rd(id_opcode) || id_opcode == OP_CMP || id_opcode == OP_CALL);
    set_addr = {1'b0, id_rd};
    set_val  = CNT_W'(WB_DIST);
    if (id_opcode == OP_CMP) begin
      set_addr = FLAGS_IDX;
      set_val  = CNT_W'(FLAG_DIST);
    end else if (id_opcode == OP_CALL) begin
      set_addr = {1'b0, RA_REG};
    end else if (is_ld(id_opcode)) begin
      set_val  = CNT_W'(LD_DIST);
    end
  end

  reg_scoreboard #(.CNT_W(CNT_W)) u_sb (
    .clk        (clk),
    .rst_n      (rst),
    .set_en_i   (set_en),
    .set_addr_i (set_addr),
    .set_val_i  (set_val),
    .rd_addr_a_i(addr_a),
    .rd_addr_b_i(addr_b),
    .rd_addr_c_i(addr_c),
    .rd_cnt_a_o (cnt_a),
    .rd_cnt_b_o (cnt_b),
    .rd_cnt_c_o (cnt_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      brc_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (issue && is_ctrl(id_opcode) && BR_BUBBLES != 0) begin
            state_q <= BR_WAIT;
            brc_q   <= BRC_W'(BR_BUBBLES);
          end
        end
        BR_WAIT: begin
          brc_q <= brc_q - BRC_W'(1);
          if (brc_q <= BRC_W'(1)) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_interlock_ctrl.sv
// Table-driven bench for hazard_interlock_ctrl with a queue of expected output records.
module tb_hazard_interlock_ctrl;
  import simplerisc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_opcode;
  logic       id_imm;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic       issue, stall_if_id, bubble_id_ex, flush_if_id;

  // Expected outputs packed as {issue, stall_if_id, bubble_id_ex, flush_if_id}.
  localparam logic [3:0] ISS = 4'b1000;
  localparam logic [3:0] STL = 4'b0110;
  localparam logic [3:0] IDL = 4'b0010;
  localparam logic [3:0] FLS = 4'b0011;
  localparam logic [3:0] ZRO = 4'b0000;

  typedef struct packed {
    logic        v;
    logic [4:0]  op;
    logic        imm;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  d;
    logic [3:0]  exp;
    logic [63:0] tag;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  hazard_interlock_ctrl #(
    .WB_DIST(3), .LD_DIST(4), .FLAG_DIST(2), .BR_BUBBLES(2)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .issue(issue),
    .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [4:0] op, input logic imm,
                              input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                              input logic [3:0] e, input logic [63:0] tag);
    vec_t x;
    x.v = v; x.op = op; x.imm = imm; x.s1 = s1; x.s2 = s2; x.d = d; x.exp = e; x.tag = tag;
    return x;
  endfunction

  task automatic T(input logic v, input logic [4:0] op, input logic imm, input logic [3:0] s1,
                   input logic [3:0] s2, input logic [3:0] d, input logic [3:0] e,
                   input logic [63:0] tag);
    vecs.push_back(mk(v, op, imm, s1, s2, d, e, tag));
  endtask

  task automatic idle(input int n);
    repeat (n) T(1'b0, OP_NOP, 1'b0, 4'd0, 4'd0, 4'd0, IDL, "idle");
  endtask

  task automatic drive(input vec_t x);
    id_valid  = x.v;
    id_opcode = x.op;
    id_imm    = x.imm;
    id_rs1    = x.s1;
    id_rs2    = x.s2;
    id_rd     = x.d;
    exp_q.push_back(x);
  endtask

  task automatic sample();
    vec_t       x;
    logic [3:0] got;
    got = {issue, stall_if_id, bubble_id_ex, flush_if_id};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL no_expect got=%b required=none", got);
    end else begin
      x = exp_q.pop_front();
      if (got !== x.exp) begin
        failures++;
        $display("FAIL %s got=%b required=%b (issue,stall,bubble,flush)", x.tag, got, x.exp);
      end
    end
  endtask

  task automatic apply(input vec_t x);
    @(posedge clk);
    #1 drive(x);
    @(negedge clk);
    sample();
  endtask

  // Asynchronous reset pulse between edges: outputs must drop while rst is low.
  task automatic reset_pulse(input logic [63:0] tag);
    #2 rst = 1'b0;
    #1 exp_q.push_back(mk(id_valid, id_opcode, id_imm, id_rs1, id_rs2, id_rd, ZRO, tag));
    sample();
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    id_valid = 1'b0; id_opcode = OP_NOP; id_imm = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    #3 exp_q.push_back(mk(1'b0, OP_NOP, 1'b0, 4'd0, 4'd0, 4'd0, ZRO, "reset"));
    sample();
    @(negedge clk) rst = 1'b1;

    // add r1 -> sub reads r1: three stalls
    T(1, OP_ADD, 0, 4'd2, 4'd3, 4'd1, ISS, "s1_add");
    repeat (3) T(1, OP_SUB, 0, 4'd1, 4'd5, 4'd4, STL, "s1_stl");
    T(1, OP_SUB, 0, 4'd1, 4'd5, 4'd4, ISS, "s1_sub");
    idle(5);
    // ld r6 -> add reads r6: four stalls; immediate form ignores rs2
    T(1, OP_LD, 1, 4'd2, 4'd0, 4'd6, ISS, "s2_ld");
    repeat (4) T(1, OP_ADD, 0, 4'd6, 4'd6, 4'd7, STL, "s2_stl");
    T(1, OP_ADD, 0, 4'd6, 4'd6, 4'd7, ISS, "s2_add");
    idle(5);
    T(1, OP_LD, 1, 4'd2, 4'd0, 4'd6, ISS, "s2_ld2");
    T(1, OP_SUB, 1, 4'd8, 4'd6, 4'd4, ISS, "s2_imm");
    idle(5);
    // cmp -> beq: two stalls, then two flush slots
    T(1, OP_CMP, 0, 4'd1, 4'd2, 4'd0, ISS, "s3_cmp");
    repeat (2) T(1, OP_BEQ, 0, 4'd0, 4'd0, 4'd0, STL, "s3_stl");
    T(1, OP_BEQ, 0, 4'd0, 4'd0, 4'd0, ISS, "s3_beq");
    repeat (2) T(1, OP_ADD, 0, 4'd9, 4'd10, 4'd11, FLS, "s3_fls");
    T(1, OP_NOP, 0, 4'd0, 4'd0, 4'd0, ISS, "s3_nop");
    idle(5);
    // mul r3 issued while cnt[r3]=1 reloads to 3
    T(1, OP_ADD, 0, 4'd1, 4'd2, 4'd3, ISS, "s4_add");
    idle(2);
    T(1, OP_MUL, 0, 4'd1, 4'd2, 4'd3, ISS, "s4_mul");
    repeat (3) T(1, OP_ADD, 0, 4'd3, 4'd0, 4'd5, STL, "s4_stl");
    T(1, OP_ADD, 0, 4'd3, 4'd0, 4'd5, ISS, "s4_rdr");
    idle(5);
    // drain by idle cycles
    T(1, OP_ADD, 0, 4'd2, 4'd3, 4'd1, ISS, "s6_add");
    idle(5);
    T(1, OP_SUB, 0, 4'd1, 4'd5, 4'd4, ISS, "s6_sub");
    idle(5);
    // call -> ret: r15 pending one cycle past the flush
    T(1, OP_CALL, 0, 4'd0, 4'd0, 4'd0, ISS, "c_call");
    repeat (2) T(1, OP_ADD, 0, 4'd1, 4'd2, 4'd3, FLS, "c_fls");
    T(1, OP_RET, 0, 4'd0, 4'd0, 4'd0, STL, "c_stl");
    T(1, OP_RET, 0, 4'd0, 4'd0, 4'd0, ISS, "c_ret");
    repeat (2) T(0, OP_NOP, 0, 4'd0, 4'd0, 4'd0, FLS, "c_fls2");
    idle(5);
    // mov/not read only rs2 (none when imm); st reads rd
    T(1, OP_ADD, 0, 4'd3, 4'd4, 4'd2, ISS, "m_add");
    T(1, OP_MOV, 0, 4'd2, 4'd10, 4'd9, ISS, "m_mov");
    T(1, OP_NOT, 1, 4'd2, 4'd2, 4'd12, ISS, "m_not");
    T(1, OP_ST, 1, 4'd11, 4'd0, 4'd2, STL, "m_stl");
    T(1, OP_ST, 1, 4'd11, 4'd0, 4'd2, ISS, "m_st");
    idle(5);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // reset during a RAW stall
    apply(mk(1, OP_ADD, 0, 4'd2, 4'd3, 4'd1, ISS, "r_add"));
    apply(mk(1, OP_SUB, 0, 4'd1, 4'd5, 4'd4, STL, "r_stl"));
    reset_pulse("r_async");
    apply(mk(1, OP_SUB, 0, 4'd1, 4'd5, 4'd4, ISS, "r_iss"));
    // reset during BR_WAIT
    apply(mk(1, OP_CALL, 0, 4'd0, 4'd0, 4'd0, ISS, "r_call"));
    apply(mk(1, OP_ADD, 0, 4'd8, 4'd9, 4'd7, FLS, "r_fls"));
    reset_pulse("r_async2");
    apply(mk(1, OP_RET, 0, 4'd0, 4'd0, 4'd0, ISS, "r_ret"));
    apply(mk(0, OP_NOP, 0, 4'd0, 4'd0, 4'd0, FLS, "r_fls2"));
    apply(mk(0, OP_NOP, 0, 4'd0, 4'd0, 4'd0, FLS, "r_fls3"));
    apply(mk(0, OP_NOP, 0, 4'd0, 4'd0, 4'd0, IDL, "r_idle"));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
